// File: rtl/zeroheti_pkg.sv
// Shared types and constants for the zeroheti OBI interconnect blocks.
//   obi_arb_idx_t  : index of a manager on a two-manager arbiter
//   ObiArbNumMgr   : number of managers sharing one arbitrated port
//   obi_arb_other  : the opposite manager index (round-robin step)
package zeroheti_pkg;

  localparam int unsigned ObiArbNumMgr = 2;

  typedef logic [0:0] obi_arb_idx_t;

  function automatic obi_arb_idx_t obi_arb_other(input obi_arb_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/zeroheti_id_fifo.sv
// Requester-ID FIFO: remembers which manager issued each accepted request so
// that in-order responses can be routed back to it.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, data_i   enqueue a manager index
//   pop_i            dequeue the head
//   head_o           oldest stored manager index
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries
module zeroheti_id_fifo
  import zeroheti_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  obi_arb_idx_t       data_i,
  input  logic               pop_i,
  output obi_arb_idx_t       head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CntW-1:0]    count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  obi_arb_idx_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Explicit wrap keeps the pointers correct for any depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/zeroheti_obi_arb.sv
// Two-to-one OBI arbiter: the core data port (m0) and the debug SBA manager
// (m1) share one downstream subordinate. Round-robin with address-phase
// locking; responses return in order and are routed via an ID FIFO.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   m0_* / m1_*           manager-side OBI (req/gnt/addr/we/be/wdata/rvalid/rdata/err)
//   sbr_*                 downstream OBI port
//   proto_err_o           sticky: response arrived with nothing outstanding
module zeroheti_obi_arb
  import zeroheti_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   m0_req_i,
  output logic                   m0_gnt_o,
  input  logic [AddrWidth-1:0]   m0_addr_i,
  input  logic                   m0_we_i,
  input  logic [DataWidth/8-1:0] m0_be_i,
  input  logic [DataWidth-1:0]   m0_wdata_i,
  output logic                   m0_rvalid_o,
  output logic [DataWidth-1:0]   m0_rdata_o,
  output logic                   m0_err_o,
  input  logic                   m1_req_i,
  output logic                   m1_gnt_o,
  input  logic [AddrWidth-1:0]   m1_addr_i,
  input  logic                   m1_we_i,
  input  logic [DataWidth/8-1:0] m1_be_i,
  input  logic [DataWidth-1:0]   m1_wdata_i,
  output logic                   m1_rvalid_o,
  output logic [DataWidth-1:0]   m1_rdata_o,
  output logic                   m1_err_o,
  output logic                   sbr_req_o,
  input  logic                   sbr_gnt_i,
  output logic [AddrWidth-1:0]   sbr_addr_o,
  output logic                   sbr_we_o,
  output logic [DataWidth/8-1:0] sbr_be_o,
  output logic [DataWidth-1:0]   sbr_wdata_o,
  input  logic                   sbr_rvalid_i,
  input  logic [DataWidth-1:0]   sbr_rdata_i,
  input  logic                   sbr_err_i,
  output logic                   proto_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  obi_arb_idx_t    prio_q, prio_d;
  logic            lock_q, lock_d;
  obi_arb_idx_t    lock_idx_q, lock_idx_d;
  logic            proto_err_q, proto_err_d;

  obi_arb_idx_t    sel;
  obi_arb_idx_t    head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            accept, push, pop;

  // Outputs are held quiet while reset is asserted so the reset cycle itself
  // presents idle values on every port.
  assign sbr_req_o = (m0_req_i | m1_req_i) & ~fifo_full & ~rst_i;
  assign accept    = sbr_req_o & sbr_gnt_i;
  assign push      = accept;
  assign pop       = sbr_rvalid_i & ~fifo_empty & ~rst_i;

  // A stalled address phase stays with its manager until it is accepted.
  always_comb begin
    sel = prio_q;
    if (lock_q) begin
      sel = lock_idx_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel = obi_arb_idx_t'(0);
    end else if (m1_req_i && !m0_req_i) begin
      sel = obi_arb_idx_t'(1);
    end
  end

  assign sbr_addr_o  = sel[0] ? m1_addr_i  : m0_addr_i;
  assign sbr_we_o    = sel[0] ? m1_we_i    : m0_we_i;
  assign sbr_be_o    = sel[0] ? m1_be_i    : m0_be_i;
  assign sbr_wdata_o = sel[0] ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o = sbr_req_o & sbr_gnt_i & ~sel[0];
  assign m1_gnt_o = sbr_req_o & sbr_gnt_i &  sel[0];

  always_comb begin
    prio_d      = prio_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    proto_err_d = proto_err_q | (sbr_rvalid_i & fifo_empty);
    if (accept) begin
      prio_d = obi_arb_other(sel);
      lock_d = 1'b0;
    end else if (sbr_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= obi_arb_idx_t'(0);
      lock_q      <= 1'b0;
      lock_idx_q  <= obi_arb_idx_t'(0);
      proto_err_q <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err_o = proto_err_q;

  zeroheti_id_fifo #(
    .Depth (MaxOutstanding)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The gating on fifo_full must keep occupancy within the FIFO depth.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   fifo_count <= CntW'(MaxOutstanding));

  // Responses go only to the manager at the FIFO head; the other sees zeros.
  assign m0_rvalid_o = pop & ~head[0];
  assign m1_rvalid_o = pop &  head[0];
  assign m0_rdata_o  = m0_rvalid_o ? sbr_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? sbr_rdata_i : '0;
  assign m0_err_o    = m0_rvalid_o & sbr_err_i;
  assign m1_err_o    = m1_rvalid_o & sbr_err_i;

endmodule

// File: tb/tb_zeroheti_obi_arb.sv
// Self-checking bench for zeroheti_obi_arb: a small reference model predicts
// grants and address muxing, and a scoreboard queue of expected requester
// IDs is checked against every response routed back to the managers.
module tb_zeroheti_obi_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW/8-1:0] m0_be;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW/8-1:0] m1_be;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          sbr_req, sbr_gnt, sbr_we, sbr_rvalid, sbr_err, proto_err;
  logic [AW-1:0] sbr_addr;
  logic [DW/8-1:0] sbr_be;
  logic [DW-1:0] sbr_wdata, sbr_rdata;

  always #5 clk = ~clk;

  zeroheti_obi_arb #(
    .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .sbr_req_o(sbr_req), .sbr_gnt_i(sbr_gnt), .sbr_addr_o(sbr_addr),
    .sbr_we_o(sbr_we), .sbr_be_o(sbr_be), .sbr_wdata_o(sbr_wdata),
    .sbr_rvalid_i(sbr_rvalid), .sbr_rdata_i(sbr_rdata), .sbr_err_i(sbr_err),
    .proto_err_o(proto_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state.
  int   exp_q[$];
  logic prio_m, lock_m, lockidx_m, proto_m;

  localparam logic [AW-1:0]   A0 = 32'h0000_1000;
  localparam logic [AW-1:0]   A1 = 32'h0000_2000;

  task automatic model_reset();
    exp_q.delete();
    prio_m    = 1'b0;
    lock_m    = 1'b0;
    lockidx_m = 1'b0;
    proto_m   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 0; m1_req = 0; sbr_gnt = 0; sbr_rvalid = 0; sbr_rdata = '0; sbr_err = 0;
    @(negedge clk);
    check_val("rst_req",    sbr_req,   0);
    check_val("rst_gnt",    {m1_gnt, m0_gnt}, 0);
    check_val("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check_val("rst_rdata0", m0_rdata,  0);
    check_val("rst_rdata1", m1_rdata,  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_val("rst_proto", proto_err, 0);
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model.
  task automatic cyc(input logic r0, input logic r1, input logic g,
                     input logic rv, input logic [31:0] rd, input logic er);
    logic exp_req, sel, resp_ok;
    int   mgr;
    m0_req = r0; m1_req = r1; sbr_gnt = g;
    sbr_rvalid = rv; sbr_rdata = rd; sbr_err = er;
    exp_req = (r0 | r1) && (exp_q.size() < MO);
    if (lock_m)       sel = lockidx_m;
    else if (r0 & r1) sel = prio_m;
    else              sel = r1;
    resp_ok = rv && (exp_q.size() > 0);
    mgr     = resp_ok ? exp_q[0] : -1;
    @(negedge clk);
    check_val("req", sbr_req, exp_req);
    check_val("gnt0", m0_gnt, exp_req & g & (sel == 1'b0));
    check_val("gnt1", m1_gnt, exp_req & g & (sel == 1'b1));
    if (exp_req) begin
      check_val("addr", sbr_addr, sel ? A1 : A0);
      check_val("we",   sbr_we,   sel ? 1'b1 : 1'b0);
    end
    check_val("rvalid0", m0_rvalid, mgr == 0);
    check_val("rvalid1", m1_rvalid, mgr == 1);
    check_val("rdata0",  m0_rdata,  (mgr == 0) ? rd : 32'h0);
    check_val("rdata1",  m1_rdata,  (mgr == 1) ? rd : 32'h0);
    check_val("err0",    m0_err,    (mgr == 0) & er);
    check_val("err1",    m1_err,    (mgr == 1) & er);
    check_val("proto",   proto_err, proto_m);
    @(posedge clk);
    #1;
    if (resp_ok) void'(exp_q.pop_front());
    if (rv && !resp_ok) proto_m = 1'b1;
    if (exp_req && g) begin
      exp_q.push_back(int'(sel));
      prio_m = ~sel;
      lock_m = 1'b0;
    end else if (exp_req) begin
      lock_m    = 1'b1;
      lockidx_m = sel;
    end
  endtask

  initial begin
    m0_addr = A0; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h1111_1111;
    m1_addr = A1; m1_we = 1'b1; m1_be = 4'h3; m1_wdata = 32'hCAFE_0001;
    model_reset();

    // Single manager read.
    do_reset();
    cyc(1, 0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 32'hDEAD_BEEF, 0);

    // Contention with pipelined responses: m0, m1, m0, m1.
    do_reset();
    cyc(1, 1, 1, 0, 32'h0, 0);
    cyc(1, 1, 1, 1, 32'h1, 0);
    cyc(1, 1, 1, 1, 32'h2, 0);
    cyc(1, 1, 1, 1, 32'h3, 0);
    cyc(0, 0, 0, 1, 32'h4, 0);

    // Lock: stalled address phase stays on m0, then m1 wins.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 32'h0, 0);
    cyc(1, 1, 1, 0, 32'h0, 0);
    cyc(1, 1, 1, 1, 32'h5, 0);
    cyc(0, 0, 0, 1, 32'h6, 1);

    // Full stall and release.
    do_reset();
    cyc(1, 1, 1, 0, 32'h0, 0);
    cyc(1, 1, 1, 0, 32'h0, 0);
    cyc(1, 1, 1, 0, 32'h0, 0);
    cyc(1, 1, 1, 1, 32'h7, 0);
    cyc(1, 1, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 32'h8, 0);
    cyc(0, 0, 0, 1, 32'h9, 0);

    // Protocol error, stickiness, and reset with a transaction outstanding.
    do_reset();
    cyc(0, 0, 0, 1, 32'hBAD, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    cyc(1, 0, 1, 0, 32'h0, 0);
    do_reset();
    cyc(1, 1, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 32'hA, 0);
    cyc(0, 0, 0, 1, 32'hB, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zeroheti_obi_arb.md
Name: zeroheti_obi_arb

Overview:
Two-to-one OBI arbiter that shares a single downstream OBI subordinate port between the core data port (manager 0) and the debug module's system-bus-access manager (manager 1).
- Arbitration is round-robin with address-phase locking.
- Responses are returned in order: a requester-ID FIFO routes each response back to the manager that issued the request.
- Sits between the debug wrapper's SBA manager, the core LSU, and the system crossbar.

Parameters:
AddrWidth, 32, address width of all ports
DataWidth, 32, data width; byte-enable width is DataWidth/8
MaxOutstanding, 2, maximum accepted-but-unanswered transactions (depth of ID FIFO, power of two, >=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m0_req_i  in  1  manager 0 request
m0_gnt_o  out  1  manager 0 grant
m0_addr_i  in  AddrWidth  manager 0 address
m0_we_i  in  1  manager 0 write enable
m0_be_i  in  DataWidth/8  manager 0 byte enable
m0_wdata_i  in  DataWidth  manager 0 write data
m0_rvalid_o  out  1  manager 0 response valid
m0_rdata_o  out  DataWidth  manager 0 read data
m0_err_o  out  1  manager 0 response error
m1_*  same set as m0_*, for manager 1 (debug SBA)
sbr_req_o  out  1  downstream request
sbr_gnt_i  in  1  downstream grant
sbr_addr_o / sbr_we_o / sbr_be_o / sbr_wdata_o  out  AddrWidth/1/DataWidth/8/DataWidth  muxed address phase
sbr_rvalid_i  in  1  downstream response valid
sbr_rdata_i  in  DataWidth  downstream read data
sbr_err_i  in  1  downstream error
proto_err_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: all gnt/rvalid/err outputs 0; sbr_req_o 0; rdata 0; proto_err_o 0; priority pointer -> manager 0; lock cleared; ID FIFO empty (count 0).
- Stall: full = (count == MaxOutstanding). While full, sbr_req_o = 0 and both m*_gnt_o = 0, even if a pop occurs in the same cycle.
- Request: sbr_req_o = (m0_req_i | m1_req_i) & !full, combinational. Zero added latency on the address phase.
- Selection when unlocked:
  - only one requester -> that one;
  - both -> the one indicated by the priority pointer.
- Lock: if sbr_req_o=1 and sbr_gnt_i=0, the selected index is registered into the lock. While locked, selection is forced to the locked index. The lock clears on the accepting handshake. A stalled address phase is never switched to the other manager.
- Address phase: sbr_addr/we/be/wdata are muxed from the selected manager. Only the selected manager's gnt follows sbr_gnt_i; the other's gnt is 0.
- Accept (sbr_req_o & sbr_gnt_i):
  - push the selected index into the ID FIFO;
  - priority pointer <- the other index (round-robin).
  - A single requester therefore never starves; with both requesting, grants alternate 0,1,0,1.
- Response:
  - on sbr_rvalid_i with FIFO non-empty: pop the head;
  - assert rvalid of the head's manager in the same cycle (combinational from FIFO head);
  - forward rdata and err to that manager; the other manager sees rvalid=0, rdata=0, err=0.
- Earliest response: the cycle after the accepting handshake; push and pop may coincide.
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged; the FIFO pointers wrap modulo MaxOutstanding.
- Protocol error: sbr_rvalid_i with FIFO empty:
  - response dropped; no manager sees rvalid;
  - proto_err_o set and held until rst_i.
- Reset mid-operation: FIFO, lock and pointer are cleared in the reset cycle and in-flight responses are lost. The downstream subordinate must be reset in the same domain and cycle.
- Request retraction: m*_req_i deasserted before gnt is an OBI violation and is not handled.

Decomposition:
- zeroheti_pkg: add a typedef for the requester index (logic [0:0]) and a constant ObiArbNumMgr = 2.
- One sub-module, zeroheti_id_fifo: synchronous FIFO of width 1, depth MaxOutstanding, with push, pop, head, full, empty and count.
- Arbitration, lock and priority logic stay in the top module.

Test Plan:
1. Single manager: m0 reads 0x0000_1000, sbr_gnt_i high, sbr_rvalid_i the next cycle with rdata 0xDEAD_BEEF -> m0_gnt_o in cycle 0, m0_rvalid_o/rdata 0xDEAD_BEEF in cycle 1, m1 outputs all 0.
2. Contention: m0 and m1 hold req for 4 accepts with gnt always high -> grants in order m0, m1, m0, m1; responses with rdata 1, 2, 3, 4 route to m0, m1, m0, m1.
3. Lock: both request, sbr_gnt_i low for 3 cycles, then high -> sbr_addr_o stays on m0's address throughout; m1 is granted on the next handshake.
4. Full stall: MaxOutstanding=2, two accepts with no response -> sbr_req_o=0 with both managers requesting. One rvalid -> stall releases the following cycle; the responses go to the correct IDs.
5. Protocol error: sbr_rvalid_i pulsed with the FIFO empty -> no m*_rvalid_o, proto_err_o=1 and sticky until rst_i; rst_i with one transaction outstanding -> count 0, proto_err_o 0, priority pointer -> m0.
